// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and constants for the instruction-cache refill sequencer.
package icache_refill_ctrl_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        RECV   = 2'd2,
        COMMIT = 2'd3
    } refill_state_e;

    localparam logic [7:0] LFSR_SEED = 8'h01;

    // Burst length field is encoded as beats minus one.
    function automatic logic [7:0] rd_len_f(input int unsigned line_words);
        return 8'(line_words - 1);
    endfunction

endpackage

// File: rtl/icache_victim_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used for pseudo-random victim way selection.
module icache_victim_lfsr
    import icache_refill_ctrl_pkg::*;
#(
    parameter int WAY_W = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             advance,
    output logic [WAY_W-1:0] way
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign way = lfsr_q[WAY_W-1:0];

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache miss/refill sequencer: one burst read per miss, fills the victim way, then writes the tag.
// Optional critical-word forwarding is enabled by defining ICACHE_CRIT_WORD_FWD_EN.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter  int ADDR_W     = WORD_W,
    parameter  int LINE_WORDS = 4,
    parameter  int SETS       = 256,
    parameter  int WAYS       = 2,
    localparam int OFF_W      = $clog2(LINE_WORDS) + 2,
    localparam int IDX_W      = $clog2(SETS),
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W,
    localparam int CNT_W      = $clog2(LINE_WORDS),
    localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_addr,
    input  logic              lookup_hit,
    input  logic              cancel,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_len,
    input  logic              rd_rdy,
    input  logic              ret_valid,
    input  logic              ret_last,
    input  logic [ADDR_W-1:0] ret_data,
    output logic              fill_we,
    output logic [WAY_W-1:0]  fill_way,
    output logic [IDX_W-1:0]  fill_index,
    output logic [CNT_W-1:0]  fill_offset,
    output logic [ADDR_W-1:0] fill_data,
    output logic              tag_we,
    output logic [TAG_W-1:0]  tag_value,
`ifdef ICACHE_CRIT_WORD_FWD_EN
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_data,
`endif
    output logic              miss_stall,
    output logic              refill_done
);

    localparam int LA_W = ADDR_W - OFF_W;

    refill_state_e    state_q, state_d;
    logic [LA_W-1:0]  line_q, line_d;
    logic [WAY_W-1:0] victim_q, victim_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cancelled_q, cancelled_d;
    logic             lfsr_adv;
    logic [WAY_W-1:0] lfsr_way;
    logic             miss;
    logic             cancelled_eff;

    icache_victim_lfsr #(.WAY_W(WAY_W)) u_lfsr (
        .clk     (clk),
        .rstn    (rstn),
        .advance (lfsr_adv),
        .way     (lfsr_way)
    );

    assign miss          = lookup_valid & ~lookup_hit & ~cancel;
    assign cancelled_eff = cancelled_q | cancel;

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        victim_d    = victim_q;
        cnt_d       = cnt_q;
        cancelled_d = cancelled_q;
        lfsr_adv    = 1'b0;
        rd_req      = 1'b0;
        rd_addr     = '0;
        rd_len      = '0;
        fill_we     = 1'b0;
        fill_data   = '0;
        tag_we      = 1'b0;
        miss_stall  = 1'b0;
        refill_done = 1'b0;

        if (state_q != IDLE && cancel) begin
            cancelled_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cancelled_d = 1'b0;
                miss_stall  = miss;
                if (miss) begin
                    line_d   = lookup_addr[ADDR_W-1:OFF_W];
                    victim_d = lfsr_way;
                    lfsr_adv = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                miss_stall = 1'b1;
                rd_req     = 1'b1;
                rd_addr    = {line_q, {OFF_W{1'b0}}};
                rd_len     = rd_len_f(LINE_WORDS);
                if (rd_rdy) begin
                    cnt_d   = '0;
                    state_d = RECV;
                end
            end
            RECV: begin
                miss_stall = 1'b1;
                if (ret_valid) begin
                    fill_we   = 1'b1;
                    fill_data = ret_data;
                    cnt_d     = cnt_q + 1'b1;
                    if (ret_last) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                // A full line wraps the beat counter back to zero; anything else leaves it invalid.
                miss_stall  = 1'b1;
                tag_we      = (cnt_q == '0);
                refill_done = tag_we & ~cancelled_eff;
                cancelled_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            line_q      <= '0;
            victim_q    <= '0;
            cnt_q       <= '0;
            cancelled_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            victim_q    <= victim_d;
            cnt_q       <= cnt_d;
            cancelled_q <= cancelled_d;
        end
    end

    assign fill_way    = victim_q;
    assign fill_index  = line_q[IDX_W-1:0];
    assign fill_offset = cnt_q;
    assign tag_value   = line_q[LA_W-1:IDX_W];

`ifdef ICACHE_CRIT_WORD_FWD_EN
    logic [CNT_W-1:0] crit_q;
    logic             unused_addr_bits;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crit_q <= '0;
        end else if (state_q == IDLE && miss) begin
            crit_q <= lookup_addr[OFF_W-1:2];
        end
    end

    assign fwd_valid        = fill_we & (cnt_q == crit_q) & ~cancelled_eff;
    assign fwd_data         = fwd_valid ? ret_data : '0;
    assign unused_addr_bits = ^lookup_addr[1:0];
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^lookup_addr[OFF_W-1:0];
`endif

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Miss/refill sequencer for the instruction cache behind the IF1 stage.
- Takes the IF1 lookup result (address plus tag-compare hit) and, on a miss, issues one burst read on the memory read channel.
- Writes the returned words into the data RAM of a chosen victim way, then writes the tag.
- Drives the fetch stall and done signals consumed by the PC/flush control.

Parameters:
ADDR_W, 32, address/word width
LINE_WORDS, 4, words per cache line (power of 2, ≥2)
SETS, 256, sets per way (power of 2)
WAYS, 2, associativity (power of 2, ≤8)
Derived, not overridable: OFF_W = log2(LINE_WORDS)+2; IDX_W = log2(SETS); TAG_W = ADDR_W-IDX_W-OFF_W; CNT_W = log2(LINE_WORDS); WAY_W = max(1, log2(WAYS))

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
lookup_valid  in  1  IF1 holds a valid fetch address this cycle
lookup_addr  in  ADDR_W  fetch address
lookup_hit  in  1  tag compare hit for lookup_addr
cancel  in  1  IF1/ID flush (redirect) this cycle
rd_req  out  1  burst read request
rd_addr  out  ADDR_W  line-aligned address (low OFF_W bits zero)
rd_len  out  8  beats minus one (= LINE_WORDS-1)
rd_rdy  in  1  request accepted
ret_valid  in  1  return beat valid
ret_last  in  1  final beat
ret_data  in  ADDR_W  return word
fill_we  out  1  data RAM write strobe
fill_way  out  WAY_W  victim way
fill_index  out  IDX_W  set index
fill_offset  out  CNT_W  word within line
fill_data  out  ADDR_W  word to write
tag_we  out  1  tag/valid write strobe
tag_value  out  TAG_W  tag written (with valid=1) at fill_way/fill_index
miss_stall  out  1  stall PC/IF1
refill_done  out  1  one-cycle pulse: line installed, re-lookup may proceed

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; all outputs 0; beat counter 0; cancelled flag 0; victim LFSR = 8'h01.
- IDLE:
  - lookup_valid & !lookup_hit & !cancel: latch line address, index, tag; latch victim = LFSR[WAY_W-1:0]; go to REQ.
  - miss_stall is combinational in IDLE: equals lookup_valid & !lookup_hit & !cancel.
- REQ:
  - rd_req=1; rd_addr and rd_len held stable until rd_rdy.
  - rd_rdy: go to RECV, counter=0. rd_req drops the cycle after the handshake.
- RECV: each ret_valid beat gives one registered-free combinational write:
  - fill_we=1, fill_offset=counter, fill_data=ret_data; counter++ (wraps at LINE_WORDS).
  - ret_last: go to COMMIT.
  - ret_valid=0 cycles: no write.
- COMMIT (one cycle), then IDLE:
  - tag_we=1, tag_value=latched tag, only if exactly LINE_WORDS beats were received (counter wrapped to 0 on last). Otherwise tag_we=0: short burst, line stays invalid.
  - refill_done=1 only if !cancelled and tag written.
- miss_stall=1 in REQ, RECV, COMMIT.
- cancel:
  - Outside IDLE, sets the cancelled flag. The bus burst is never aborted; fill and tag writes still complete.
  - cancel and miss in the same IDLE cycle: no refill.
  - cancelled flag clears on entry to IDLE.
- Extra beats after ret_last are ignored (state is no longer RECV).
- Victim LFSR:
  - 8-bit, taps x^8+x^6+x^5+x^4+1.
  - Advances every cycle a refill is accepted out of IDLE.
- Reset asserted mid-burst: immediate return to IDLE. Outstanding beats arriving afterwards are ignored.

Optional Feature:
- Macro ICACHE_CRIT_WORD_FWD_EN.
- Defined: adds outputs fwd_valid (1) and fwd_data (ADDR_W).
  - fwd_valid pulses on the RECV beat whose counter equals lookup_addr[OFF_W-1:2] as latched at miss, when !cancelled.
  - fwd_data = ret_data on that beat.
  - refill_done is still produced.
- Undefined: ports absent; the instruction is only delivered via re-lookup after refill_done.

Decomposition:
- Shared package/header (extend CPU_Parameter.vh):
  - WORD width.
  - State encoding: IDLE=2'd0, REQ=2'd1, RECV=2'd2, COMMIT=2'd3.
  - rd_len constant.
  - LFSR seed.
- One natural sub-module: icache_victim_lfsr (8-bit LFSR with advance enable, WAY_W output slice).

Test Plan:
1. Hit: lookup_valid=1, lookup_hit=1 at 0x1C000000 → no rd_req, miss_stall=0.
2. Miss at 0x1C000014: rd_req with rd_addr=0x1C000010, rd_len=3; rd_rdy after 2 cycles; 4 beats D0..D3 with gaps.
   - Expect fill_we at offsets 0..3 with matching data, index=0x01.
   - Then tag_we, tag_value=0x1C000>>(IDX_W+OFF_W-12) correct, refill_done pulse; miss_stall high from miss until COMMIT inclusive.
3. cancel asserted during RECV beat 2 → all 4 fills and tag_we still occur, refill_done=0, next miss accepted normally.
4. ret_last on beat 3 of 4 → tag_we=0, refill_done=0, return to IDLE.
5. rstn low during RECV → outputs 0 asynchronously, state IDLE; stray ret_valid ignored; fresh miss works.
6. ICACHE_CRIT_WORD_FWD_EN: miss at offset 0x8 → fwd_valid on beat 2 with fwd_data=D2; with cancel set beforehand → no fwd_valid.
